// File: rtl/stack_transfer_pkg.sv
// Shared types and constants for the PUSH/POP stack transfer sequencer.
package stack_transfer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    PUSH_SEL,
    PUSH_WR,
    POP_RD,
    POP_WAIT,
    POP_WB,
    DONE
  } state_t;

  localparam int unsigned SP_REG = 14;
  localparam int unsigned PC_REG = 15;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/stack_transfer_unit_bit_finder.sv
// Lowest-set-bit finder used to walk the remaining register list in ascending order.
module priority_bit_finder (
  input  logic [15:0] mask,
  output logic [3:0]  index,
  output logic        found
);

  // Descending loop so the lowest set bit is the last assignment and wins.
  always_comb begin
    index = '0;
    found = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) begin
        index = 4'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stack_transfer_unit.sv
// Multi-cycle PUSH/POP sequencer moving a register list between the bank and a
// full-descending, word-addressed stack in data memory.
//
// state    | meaning
// IDLE     | waiting for start
// CHECK    | empty-list / overflow / underflow decision, load base pointer
// PUSH_SEL | reg_sel presented, bank read in flight
// PUSH_WR  | store one register word
// POP_RD   | issue one memory read
// POP_WAIT | down-count the memory read latency
// POP_WB   | hold write-back until the bank acknowledges
// DONE     | one-cycle completion pulse
module stack_transfer_unit
  import stack_transfer_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter int MEM_READ_LATENCY = 1,
  parameter int STACK_TOP        = 8191
) (
  input  logic                  fast_clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_pop,
  input  logic [15:0]           reg_list,
  input  logic [DATA_WIDTH-1:0] sp_in,
  output logic [3:0]            reg_sel,
  input  logic [DATA_WIDTH-1:0] reg_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wb_valid,
  output logic [3:0]            wb_reg,
  output logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  wb_ack,
  output logic [DATA_WIDTH-1:0] new_sp,
  output logic                  busy,
  output logic                  done,
  output logic                  fault
);

  localparam logic [DATA_WIDTH:0] POP_LIMIT = (DATA_WIDTH+1)'(longint'(STACK_TOP) + 1);
  localparam logic [1:0]          WAIT_LOAD = 2'(MEM_READ_LATENCY - 1);

  state_t                  state;
  logic                    pop_q;
  logic [15:0]             mask_q;
  logic [DATA_WIDTH-1:0]   sp_q;
  logic [4:0]              count_q;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [3:0]              cur_idx;
  logic [1:0]              wait_cnt;
  logic [DATA_WIDTH-1:0]   result_sp;

  logic [3:0]              nxt_idx;
  logic                    nxt_found;
  logic [DATA_WIDTH-1:0]   count_ext;
  logic [DATA_WIDTH:0]     pop_end;
  logic                    push_fault;
  logic                    pop_fault;
  logic                    cur_special;
  logic [ADDR_WIDTH-1:0]   ptr_inc;
  logic [15:0]             nxt_onehot;

  // mask_q never contains the register currently being moved, so the finder
  // always points at the next one and found doubles as "more to do".
  priority_bit_finder u_finder (
    .mask  (mask_q),
    .index (nxt_idx),
    .found (nxt_found)
  );

  assign count_ext   = DATA_WIDTH'(count_q);
  assign pop_end     = {1'b0, sp_q} + (DATA_WIDTH+1)'(count_q);
  assign push_fault  = !pop_q && (count_ext > sp_q);
  assign pop_fault   = pop_q && (pop_end > POP_LIMIT);
  assign cur_special = (cur_idx == 4'(SP_REG)) || (cur_idx == 4'(PC_REG));
  assign ptr_inc     = ptr + 1'b1;
  assign nxt_onehot  = 16'b1 << nxt_idx;

  // Bank read data only becomes valid in PUSH_WR, so the store data bypasses the register stage.
  assign mem_wdata = mem_we ? reg_data : '0;

  always_ff @(posedge fast_clock) begin
    if (reset) begin
      state     <= IDLE;
      pop_q     <= 1'b0;
      mask_q    <= '0;
      sp_q      <= '0;
      count_q   <= '0;
      ptr       <= '0;
      cur_idx   <= '0;
      wait_cnt  <= '0;
      result_sp <= '0;
      reg_sel   <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      wb_valid  <= 1'b0;
      wb_reg    <= '0;
      wb_data   <= '0;
      new_sp    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      done   <= 1'b0;
      fault  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pop_q   <= is_pop;
            mask_q  <= reg_list;
            sp_q    <= sp_in;
            count_q <= popcount16(reg_list);
            busy    <= 1'b1;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (count_q == 5'd0 || push_fault || pop_fault) begin
            new_sp <= sp_q;
            done   <= 1'b1;
            fault  <= (count_q != 5'd0);
            state  <= DONE;
          end else begin
            cur_idx <= nxt_idx;
            mask_q  <= mask_q & ~nxt_onehot;
            if (pop_q) begin
              result_sp <= sp_q + count_ext;
              ptr       <= ADDR_WIDTH'(sp_q);
              mem_addr  <= ADDR_WIDTH'(sp_q);
              mem_re    <= 1'b1;
              state     <= POP_RD;
            end else begin
              result_sp <= sp_q - count_ext;
              ptr       <= ADDR_WIDTH'(sp_q - count_ext);
              reg_sel   <= nxt_idx;
              state     <= PUSH_SEL;
            end
          end
        end
        PUSH_SEL: begin
          mem_we   <= 1'b1;
          mem_addr <= ptr;
          state    <= PUSH_WR;
        end
        PUSH_WR: begin
          ptr <= ptr_inc;
          if (nxt_found) begin
            reg_sel <= nxt_idx;
            cur_idx <= nxt_idx;
            mask_q  <= mask_q & ~nxt_onehot;
            state   <= PUSH_SEL;
          end else begin
            new_sp <= result_sp;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        POP_RD: begin
          wait_cnt <= WAIT_LOAD;
          state    <= POP_WAIT;
        end
        POP_WAIT: begin
          if (wait_cnt != 2'd0) begin
            wait_cnt <= wait_cnt - 2'd1;
          end else if (!cur_special) begin
            wb_valid <= 1'b1;
            wb_reg   <= cur_idx;
            wb_data  <= mem_rdata;
            state    <= POP_WB;
          end else begin
            // SP/PC words are consumed without a write-back.
            ptr <= ptr_inc;
            if (nxt_found) begin
              cur_idx  <= nxt_idx;
              mask_q   <= mask_q & ~nxt_onehot;
              mem_addr <= ptr_inc;
              mem_re   <= 1'b1;
              state    <= POP_RD;
            end else begin
              new_sp <= result_sp;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        POP_WB: begin
          if (wb_ack) begin
            wb_valid <= 1'b0;
            ptr      <= ptr_inc;
            if (nxt_found) begin
              cur_idx  <= nxt_idx;
              mask_q   <= mask_q & ~nxt_onehot;
              mem_addr <= ptr_inc;
              mem_re   <= 1'b1;
              state    <= POP_RD;
            end else begin
              new_sp <= result_sp;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
